// File: rtl/aes_sm_pkg.sv
// ---------------------------------------------------------------------------
// aes_sm_pkg
//   Types shared by the AES memory state machines:
//   - state encodings for the read-side and write-side sequencers
//   - the subset of CCI-P / CCI-MPF c1 channel types these blocks use
//     (line address, write header, write response) and their helpers.
// ---------------------------------------------------------------------------
`default_nettype none

package aes_sm_pkg;

  // Register stages between FIFO pop and c1TxValid.
  localparam int WR_PIPE_DEPTH = 2;

  // Write-side sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } t_wr_sm_state;

  // Read-side sequencer.
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } t_rd_sm_state;

  // CCI basic types.
  typedef logic [41:0]  t_cci_clAddr;
  typedef logic [15:0]  t_cci_mdata;
  typedef logic [511:0] t_cci_clData;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_cci_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_cci_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_cci_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_cci_c1_rsp;

  // MPF per-request options.
  typedef struct packed {
    logic       checkLoadStoreOrder;
    logic       mapVAtoPhysChannel;
    logic       addrIsVirtual;
    t_cci_vc    vc_sel;
    t_cci_clLen cl_len;
  } t_cci_mpf_ReqHdrParams;

  // MPF c1 write request header: MPF extension bits above the CCI-P header.
  typedef struct packed {
    logic        checkLoadStoreOrder;
    logic        mapVAtoPhysChannel;
    logic        addrIsVirtual;
    logic [5:0]  rsvd0;
    t_cci_vc     vc_sel;
    logic        sop;
    logic [1:0]  rsvd1;
    t_cci_clLen  cl_len;
    t_cci_c1_req req_type;
    logic [5:0]  rsvd2;
    t_cci_clAddr address;
    t_cci_mdata  mdata;
  } t_cci_mpf_c1_ReqMemHdr;

  localparam int CCI_MPF_C1TX_MEMHDR_WIDTH = $bits(t_cci_mpf_c1_ReqMemHdr);

  // c1 response channel fields consumed by the write sequencer.
  typedef struct packed {
    logic        rspValid;
    t_cci_c1_rsp rspType;
  } t_if_ccip_c1_Rx;

  function automatic logic cci_c1Rx_isWriteRsp(input t_if_ccip_c1_Rx rx);
    return rx.rspValid && (rx.rspType == eRSP_WRLINE);
  endfunction

  function automatic t_cci_mpf_ReqHdrParams cci_mpf_defaultReqHdrParams(
    input logic use_virtual_addr
  );
    t_cci_mpf_ReqHdrParams p;
    p.checkLoadStoreOrder = 1'b1;
    p.mapVAtoPhysChannel  = 1'b0;
    p.addrIsVirtual       = use_virtual_addr;
    p.vc_sel              = eVC_VA;
    p.cl_len              = eCL_LEN_1;
    return p;
  endfunction

  function automatic t_cci_mpf_c1_ReqMemHdr cci_mpf_c1_genReqHdr(
    input t_cci_c1_req           req_type,
    input t_cci_clAddr           address,
    input t_cci_mdata            mdata,
    input t_cci_mpf_ReqHdrParams params
  );
    t_cci_mpf_c1_ReqMemHdr h;
    h                     = '0;
    h.checkLoadStoreOrder = params.checkLoadStoreOrder;
    h.mapVAtoPhysChannel  = params.mapVAtoPhysChannel;
    h.addrIsVirtual       = params.addrIsVirtual;
    h.vc_sel              = params.vc_sel;
    h.cl_len              = params.cl_len;
    h.sop                 = 1'b1;
    h.req_type            = req_type;
    h.address             = address;
    h.mdata               = mdata;
    return h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_to_mpf_wr_stage.sv
// ---------------------------------------------------------------------------
// buffer_to_mpf_wr_stage
//   Two-stage issue pipeline: stage 1 holds the line address while the FIFO
//   delivers its data, stage 2 is the registered c1 write request.
//   Ports:
//     clk, reset      clock, synchronous active-low reset
//     issue           FIFO pop this cycle (one line issued)
//     issue_addr      VA line address of the line being issued
//     buffer_data     FIFO data, valid the cycle after issue
//     s1_valid        stage 1 occupied (line in flight toward c1Tx)
//     tx_valid        c1 write request valid
//     tx_hdr          c1 write header
//     tx_data         c1 write payload
// ---------------------------------------------------------------------------
`default_nettype none

module buffer_to_mpf_wr_stage
  import aes_sm_pkg::*;
#(
  parameter t_cci_mdata MDATA_TAG = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  t_cci_clAddr           issue_addr,
  input  t_cci_clData           buffer_data,
  output logic                  s1_valid,
  output logic                  tx_valid,
  output t_cci_mpf_c1_ReqMemHdr tx_hdr,
  output t_cci_clData           tx_data
);

  t_cci_clAddr s1_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      tx_valid <= 1'b0;
      tx_hdr   <= '0;
      tx_data  <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_addr <= issue_addr;
      end

      // buffer_data is valid now because stage 1 popped last cycle.
      tx_valid <= s1_valid;
      if (s1_valid) begin
        tx_hdr  <= cci_mpf_c1_genReqHdr(eREQ_WRLINE_I, s1_addr, MDATA_TAG,
                                        cci_mpf_defaultReqHdrParams(1'b1));
        tx_data <= buffer_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/buffer_to_mpf_sm.sv
// ---------------------------------------------------------------------------
// buffer_to_mpf_sm
//   Drains data_length cache lines from the AES output FIFO and writes them
//   with MPF c1 WRLINE_I requests to consecutive VA lines from first_clAddr.
//   done rises once every issued line has been acknowledged.
//   Ports:
//     clk, reset        clock, synchronous active-low reset
//     run               start pulse (accepted in IDLE only)
//     data_length       number of lines to write
//     first_clAddr      first VA cache-line address
//     done              high while idle
//     c1TxAlmFull       MPF c1 almost-full
//     c1TxValid         write request valid
//     reqMemHdr         write request header
//     reqData           write request payload
//     c1Rx              c1 response channel
//     buffer_rd_enable  FIFO pop
//     buffer_data       FIFO data (1-cycle read latency)
//     buffer_empty      FIFO empty
// ---------------------------------------------------------------------------
`default_nettype none

module buffer_to_mpf_sm
  import aes_sm_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 64,
  parameter t_cci_mdata MDATA_TAG       = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 run,
  input  logic [63:0]                          data_length,
  input  t_cci_clAddr                          first_clAddr,
  output logic                                 done,
  input  logic                                 c1TxAlmFull,
  output logic                                 c1TxValid,
  output logic [CCI_MPF_C1TX_MEMHDR_WIDTH-1:0] reqMemHdr,
  output logic [511:0]                         reqData,
  input  t_if_ccip_c1_Rx                       c1Rx,
  output logic                                 buffer_rd_enable,
  input  logic [511:0]                         buffer_data,
  input  logic                                 buffer_empty
);

  t_wr_sm_state          state;
  t_wr_sm_state          state_next;
  logic [63:0]           issued;
  logic [63:0]           acked;
  logic                  rd_en;
  logic                  wr_rsp;
  logic                  s1_valid;
  t_cci_clAddr           issue_addr;
  t_cci_mpf_c1_ReqMemHdr hdr;

  // Outstanding count includes lines still in the issue pipeline, so the
  // limit holds even before c1TxValid is seen by MPF.
  always_comb begin
    rd_en = (state == RUN) && !buffer_empty && !c1TxAlmFull &&
            (issued < data_length) &&
            ((issued - acked) < 64'(MAX_OUTSTANDING));
  end

  assign wr_rsp           = cci_c1Rx_isWriteRsp(c1Rx) && (state != IDLE);
  assign buffer_rd_enable = rd_en;
  assign done             = (state == IDLE);
  // Address arithmetic wraps at the line-address width.
  assign issue_addr       = first_clAddr + t_cci_clAddr'(issued[$bits(t_cci_clAddr)-1:0]);
  assign reqMemHdr        = hdr;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = RUN;
      RUN:     if ((issued == data_length) && !s1_valid) state_next = DRAIN;
      DRAIN:   if (acked >= data_length) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      issued <= '0;
      acked  <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && run) begin
        issued <= '0;
        acked  <= '0;
      end else begin
        if (rd_en)  issued <= issued + 64'd1;
        if (wr_rsp) acked  <= acked + 64'd1;
      end
    end
  end

  buffer_to_mpf_wr_stage #(
    .MDATA_TAG (MDATA_TAG)
  ) u_wr_stage (
    .clk         (clk),
    .reset       (reset),
    .issue       (rd_en),
    .issue_addr  (issue_addr),
    .buffer_data (buffer_data),
    .s1_valid    (s1_valid),
    .tx_valid    (c1TxValid),
    .tx_hdr      (hdr),
    .tx_data     (reqData)
  );

endmodule

`default_nettype wire

// File: tb/tb_buffer_to_mpf_sm.sv
`default_nettype none

module tb_buffer_to_mpf_sm;
  import aes_sm_pkg::*;

  localparam int HW = CCI_MPF_C1TX_MEMHDR_WIDTH;
  localparam logic [15:0] TAG = 16'h00A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1 (default outstanding limit, FIFO model)
  logic           reset, run, almfull;
  logic [63:0]    len;
  t_cci_clAddr    addr;
  t_if_ccip_c1_Rx rx;
  logic           done, txv, rd_en, bempty;
  logic [HW-1:0]  hdr_raw;
  logic [511:0]   rdata, bdata;

  // DUT 2 (outstanding limit 2, FIFO never empty)
  logic           run2;
  logic [63:0]    len2;
  t_if_ccip_c1_Rx rx2;
  logic           done2, txv2, rd_en2;
  logic [HW-1:0]  hdr2;
  logic [511:0]   rdata2;

  buffer_to_mpf_sm #(.MAX_OUTSTANDING(64), .MDATA_TAG(TAG)) dut (
    .clk(clk), .reset(reset), .run(run), .data_length(len), .first_clAddr(addr),
    .done(done), .c1TxAlmFull(almfull), .c1TxValid(txv), .reqMemHdr(hdr_raw),
    .reqData(rdata), .c1Rx(rx), .buffer_rd_enable(rd_en), .buffer_data(bdata),
    .buffer_empty(bempty)
  );

  buffer_to_mpf_sm #(.MAX_OUTSTANDING(2), .MDATA_TAG(16'h0)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .data_length(len2), .first_clAddr(42'h40),
    .done(done2), .c1TxAlmFull(1'b0), .c1TxValid(txv2), .reqMemHdr(hdr2),
    .reqData(rdata2), .c1Rx(rx2), .buffer_rd_enable(rd_en2), .buffer_data({16{32'h1234_5678}}),
    .buffer_empty(1'b0)
  );

  // FIFO model, 1-cycle read latency
  logic [511:0] fmem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bempty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rd_en && !bempty) begin
      bdata  <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Request monitor
  int vcnt = 0, rdcnt = 0, v2cnt = 0, cyc = 0;
  logic [HW-1:0]  lhdr  [32];
  logic [511:0]   ldata [32];
  int             lcyc  [32];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txv && vcnt < 32) begin
      lhdr[vcnt]  <= hdr_raw;
      ldata[vcnt] <= rdata;
      lcyc[vcnt]  <= cyc;
      vcnt        <= vcnt + 1;
    end
    if (rd_en)  rdcnt <= rdcnt + 1;
    if (txv2)   v2cnt <= v2cnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] dpat(input int k);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'hC0DE_0000 + 32'(k * 16 + i);
    return d;
  endfunction

  // Expected header built field by field
  function automatic logic [HW-1:0] exp_hdr(input t_cci_clAddr a);
    t_cci_mpf_c1_ReqMemHdr h;
    h = '0;
    h.checkLoadStoreOrder = 1'b1;
    h.mapVAtoPhysChannel  = 1'b0;
    h.addrIsVirtual       = 1'b1;
    h.vc_sel              = eVC_VA;
    h.sop                 = 1'b1;
    h.cl_len              = eCL_LEN_1;
    h.req_type            = eREQ_WRLINE_I;
    h.address             = a;
    h.mdata               = TAG;
    return h;
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = dpat(wr_ptr);
      wr_ptr++;
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic send_rsp(input int n);
    for (int i = 0; i < n; i++) begin
      rx = '{rspValid: 1'b1, rspType: eRSP_WRLINE};
      @(negedge clk);
    end
    rx = '0;
  endtask

  task automatic send_rsp2(input int n);
    for (int i = 0; i < n; i++) begin
      rx2 = '{rspValid: 1'b1, rspType: eRSP_WRLINE};
      @(negedge clk);
    end
    rx2 = '0;
  endtask

  task automatic wait_v(input int target, input int budget, input string tag);
    int k = 0;
    while (vcnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 512'(vcnt), 512'(target));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 512'(done), 512'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_hi;
    int k;
    reset = 1'b0; run = 1'b0; run2 = 1'b0; almfull = 1'b0;
    len = '0; len2 = '0; addr = '0; rx = '0; rx2 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_done",  512'(done),    512'(1));
    chk("rst_valid", 512'(txv),     512'(0));
    chk("rst_hdr",   512'(hdr_raw), 512'(0));
    chk("rst_data",  rdata,         512'(0));
    chk("rst_rden",  512'(rd_en),   512'(0));
    chk("rst_done2", 512'(done2),   512'(1));

    // Four lines, back to back
    push(4);
    len = 64'd4; addr = 42'h1000;
    reset = 1'b1;
    @(negedge clk);
    pulse_run();
    wait_v(4, 20, "t1_count");
    for (int i = 0; i < 4; i++) begin
      chk("t1_hdr",  512'(lhdr[i]), 512'(exp_hdr(42'h1000 + 42'(i))));
      chk("t1_data", ldata[i], dpat(i));
      if (i > 0) chk("t1_b2b", 512'(lcyc[i] - lcyc[i-1]), 512'(1));
    end
    chk("t1_rdcnt", 512'(rdcnt), 512'(4));
    chk("t1_busy",  512'(done),  512'(0));
    send_rsp(4);
    chk("t1_done_lag", 512'(done), 512'(0));
    @(negedge clk);
    chk("t1_done", 512'(done), 512'(1));

    // Zero-length job: data available but must not be popped
    push(8);
    len = 64'd0;
    pulse_run();
    chk("t2_low1", 512'(done), 512'(0));
    @(negedge clk);
    chk("t2_low2", 512'(done), 512'(0));
    @(negedge clk);
    chk("t2_done", 512'(done), 512'(1));
    chk("t2_nov",  512'(vcnt),  512'(4));
    chk("t2_nord", 512'(rdcnt), 512'(4));

    // Eight lines with almost-full after the third issue
    len = 64'd8; addr = 42'h2000;
    pulse_run();
    k = 0;
    while (rdcnt < 7 && k < 20) begin
      @(negedge clk);
      k++;
    end
    almfull = 1'b1;
    chk("t3_three", 512'(rdcnt), 512'(7));
    rd_hi = 0;
    for (int i = 0; i < 10; i++) begin
      rx = (i < 3) ? '{rspValid: 1'b1, rspType: eRSP_WRLINE} : '0;
      @(negedge clk);
      if (rd_en) rd_hi++;
    end
    rx = '0;
    chk("t3_rden_low", 512'(rd_hi), 512'(0));
    chk("t3_rdcnt_hold", 512'(rdcnt), 512'(7));
    chk("t3_valids_le5", 512'((vcnt - 4) <= 5), 512'(1));
    almfull = 1'b0;
    wait_v(12, 40, "t3_count");
    for (int i = 4; i < 12; i++) begin
      chk("t3_hdr",  512'(lhdr[i]), 512'(exp_hdr(42'h2000 + 42'(i - 4))));
      chk("t3_data", ldata[i], dpat(i));
    end
    chk("t3_rdcnt", 512'(rdcnt), 512'(12));
    send_rsp(5);
    wait_done(10, "t3_done");

    // Outstanding limit of 2 with responses withheld
    len2 = 64'd5;
    run2 = 1'b1;
    @(negedge clk);
    run2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_two", 512'(v2cnt), 512'(2));
    for (int i = 3; i <= 5; i++) begin
      send_rsp2(1);
      repeat (5) @(negedge clk);
      chk("t4_release", 512'(v2cnt), 512'(i));
    end
    send_rsp2(1);
    repeat (5) @(negedge clk);
    chk("t4_len_cap", 512'(v2cnt), 512'(5));
    chk("t4_busy", 512'(done2), 512'(0));
    send_rsp2(1);
    repeat (3) @(negedge clk);
    chk("t4_done", 512'(done2), 512'(1));

    // Address wrap
    push(2);
    len = 64'd2; addr = '1;
    pulse_run();
    wait_v(14, 20, "t5_count");
    chk("t5_hdr_top",  512'(lhdr[12]), 512'(exp_hdr('1)));
    chk("t5_hdr_wrap", 512'(lhdr[13]), 512'(exp_hdr('0)));
    chk("t5_data", ldata[13], dpat(13));
    send_rsp(2);
    wait_done(10, "t5_done");

    // Reset during DRAIN with three lines unacknowledged
    push(3);
    len = 64'd3; addr = 42'h3000;
    pulse_run();
    wait_v(17, 20, "t6_count");
    repeat (2) @(negedge clk);
    chk("t6_busy", 512'(done), 512'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("t6_done",  512'(done),  512'(1));
    chk("t6_valid", 512'(txv),   512'(0));
    chk("t6_rden",  512'(rd_en), 512'(0));
    reset = 1'b1;
    send_rsp(3);
    repeat (2) @(negedge clk);
    chk("t6_idle", 512'(done), 512'(1));
    chk("t6_nov",  512'(vcnt), 512'(17));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
